dlk_write_guard: RTL and testbench

- Write-side counterpart of the DLK read-overflow checker.
- Keeps a table of live data-block base addresses, with explicit allocate and free.
- Checks store accesses with a req/rsp handshake. An iterative scan finds the closest registered base above the store's block base and flags writes that reach or cross it.
- Sits beside the LSU store path. One check is in flight at a time.

---
 rtl/dlk_pkg.sv | 36 +++
 rtl/dlk_alloc_table.sv | 140 ++++++++++++++
 rtl/dlk_write_guard.sv | 145 ++++++++++++++
 tb/tb_dlk_write_guard.sv | 342 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dlk_pkg.sv
// dlk_pkg: shared types and constants for the DLK store-side write guard.
//
// Contents:
//   DLK_AW          address width of a stored table entry; the guard's AW must not exceed it
//   DLK_NO_BOUND    all-ones bound, meaning no higher base was found
//   dlk_entry_t     one table entry {valid, base}; address 0 is a legal base
//   dlk_chk_state_e check FSM states
//   dlk_tightens()  true when an entry narrows the current bound for a check

package dlk_pkg;

    localparam int unsigned DLK_AW = 32;

    localparam logic [DLK_AW-1:0] DLK_NO_BOUND = '1;

    typedef struct packed {
        logic              valid;
        logic [DLK_AW-1:0] base;
    } dlk_entry_t;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StScan = 2'd1,
        StResp = 2'd2
    } dlk_chk_state_e;

    // An entry narrows the bound if it lies strictly above the block being written
    // and strictly below the closest higher base seen so far.
    function automatic logic dlk_tightens(input logic              valid,
                                          input logic [DLK_AW-1:0] base,
                                          input logic [DLK_AW-1:0] lat_base,
                                          input logic [DLK_AW-1:0] bound);
        return valid && (base > lat_base) && (base < bound);
    endfunction

endpackage

// File: rtl/dlk_alloc_table.sv
// dlk_alloc_table: table of live data-block base addresses.
//
// Ports:
//   clk_i, rst_ni        clock, asynchronous active-low reset
//   clear_i              synchronous clear of every entry, count and drop flag
//   alloc_valid_i/addr_i register a base (ignored if already present)
//   free_valid_i/addr_i  deregister a base (no-op if absent)
//   rd_idx_i             read port index driven by the scanning FSM
//   rd_valid_o/base_o    entry contents at rd_idx_i (current, pre-edge table)
//   full_o, count_o      registered occupancy after the edge
//   alloc_drop_o         sticky: an alloc found no free slot

module dlk_alloc_table
    import dlk_pkg::*;
#(
    parameter int unsigned SIZE = 32,
    parameter int unsigned AW   = 32,
    localparam int unsigned IW  = $clog2(SIZE)
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          clear_i,
    input  logic          alloc_valid_i,
    input  logic [AW-1:0] alloc_addr_i,
    input  logic          free_valid_i,
    input  logic [AW-1:0] free_addr_i,
    input  logic [IW-1:0] rd_idx_i,
    output logic          rd_valid_o,
    output logic [AW-1:0] rd_base_o,
    output logic          full_o,
    output logic [IW:0]   count_o,
    output logic          alloc_drop_o
);

    dlk_entry_t entries_q [SIZE];
    dlk_entry_t entries_d [SIZE];

    logic [IW:0]   count_q, count_d;
    logic          full_q, full_d;
    logic          drop_q, drop_d;

    logic          alloc_dup;
    logic          free_hit;
    logic [IW-1:0] free_idx;
    logic          slot_found;
    logic [IW-1:0] slot_idx;
    logic          same_addr;
    logic          alloc_try;
    logic          alloc_do;
    logic          free_do;

    // Match detection and lowest-free priority encoder. Both look at the table
    // before this edge, so a slot freed this cycle is not offered to the alloc.
    always_comb begin
        alloc_dup  = 1'b0;
        free_hit   = 1'b0;
        free_idx   = '0;
        slot_found = 1'b0;
        slot_idx   = '0;
        for (int i = 0; i < int'(SIZE); i++) begin
            if (entries_q[i].valid && (entries_q[i].base[AW-1:0] == alloc_addr_i)) begin
                alloc_dup = 1'b1;
            end
            if (entries_q[i].valid && (entries_q[i].base[AW-1:0] == free_addr_i) && !free_hit) begin
                free_hit = 1'b1;
                free_idx = IW'(i);
            end
        end
        // Descending walk: the last hit written is the lowest invalid index.
        for (int i = int'(SIZE) - 1; i >= 0; i--) begin
            if (!entries_q[i].valid) begin
                slot_found = 1'b1;
                slot_idx   = IW'(i);
            end
        end
    end

    // Alloc and free of the same address in one cycle: the free wins, even when
    // the address is not in the table (then nothing happens at all).
    assign same_addr = alloc_valid_i && free_valid_i && (alloc_addr_i == free_addr_i);
    assign free_do   = free_valid_i && free_hit;
    assign alloc_try = alloc_valid_i && !alloc_dup && !same_addr;
    assign alloc_do  = alloc_try && slot_found;

    always_comb begin
        for (int i = 0; i < int'(SIZE); i++) begin
            entries_d[i] = entries_q[i];
        end
        count_d = count_q;
        drop_d  = drop_q;

        if (clear_i) begin
            for (int i = 0; i < int'(SIZE); i++) begin
                entries_d[i] = '0;
            end
            count_d = '0;
            drop_d  = 1'b0;
        end else begin
            // free_idx points at a valid slot and slot_idx at an invalid one,
            // so the two writes never collide.
            if (free_do) begin
                entries_d[free_idx].valid = 1'b0;
            end
            if (alloc_do) begin
                entries_d[slot_idx].valid = 1'b1;
                entries_d[slot_idx].base  = DLK_AW'(alloc_addr_i);
            end
            if (alloc_try && !slot_found) begin
                drop_d = 1'b1;
            end
            count_d = count_q + (IW+1)'(alloc_do) - (IW+1)'(free_do);
        end
        full_d = (count_d == (IW+1)'(SIZE));
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < int'(SIZE); i++) begin
                entries_q[i] <= '0;
            end
            count_q <= '0;
            full_q  <= 1'b0;
            drop_q  <= 1'b0;
        end else begin
            for (int i = 0; i < int'(SIZE); i++) begin
                entries_q[i] <= entries_d[i];
            end
            count_q <= count_d;
            full_q  <= full_d;
            drop_q  <= drop_d;
        end
    end

    assign rd_valid_o   = entries_q[rd_idx_i].valid;
    assign rd_base_o    = entries_q[rd_idx_i].base[AW-1:0];
    assign full_o       = full_q;
    assign count_o      = count_q;
    assign alloc_drop_o = drop_q;

endmodule

// File: rtl/dlk_write_guard.sv
// dlk_write_guard: checks LSU stores against the table of live block bases.
// A check scans every table slot, one per cycle, to find the closest
// registered base above the store's block base; the store overflows if its
// address reaches or crosses that bound. One check in flight at a time.
//
// Ports:
//   clk_i, rst_ni                  clock, asynchronous active-low reset
//   clear_i                        synchronous clear of table and FSM (aborts a check)
//   alloc_valid_i, alloc_addr_i    register a block base
//   free_valid_i, free_addr_i      deregister a block base
//   chk_valid_i, chk_ready_o       store check request handshake
//   chk_base_i, chk_addr_i         block base and store address of the request
//   rsp_valid_o, rsp_ready_i       result handshake
//   rsp_overflow_o, rsp_bound_o    result: overflow flag, closest higher base
//   full_o, count_o, alloc_drop_o  table occupancy and sticky drop flag
//
// Request accepted at edge T: SIZE scan cycles follow, and the result is shown
// from edge T+SIZE until consumed. AW must not exceed dlk_pkg::DLK_AW.

module dlk_write_guard
    import dlk_pkg::*;
#(
    parameter int unsigned SIZE = 32,
    parameter int unsigned AW   = 32,
    localparam int unsigned IW  = $clog2(SIZE)
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          clear_i,
    input  logic          alloc_valid_i,
    input  logic [AW-1:0] alloc_addr_i,
    input  logic          free_valid_i,
    input  logic [AW-1:0] free_addr_i,
    input  logic          chk_valid_i,
    output logic          chk_ready_o,
    input  logic [AW-1:0] chk_base_i,
    input  logic [AW-1:0] chk_addr_i,
    output logic          rsp_valid_o,
    input  logic          rsp_ready_i,
    output logic          rsp_overflow_o,
    output logic [AW-1:0] rsp_bound_o,
    output logic          full_o,
    output logic [IW:0]   count_o,
    output logic          alloc_drop_o
);

    dlk_chk_state_e state_q, state_d;
    logic [IW-1:0]  idx_q, idx_d;
    logic [AW-1:0]  bound_q, bound_d;
    logic [AW-1:0]  lat_base_q, lat_base_d;
    logic [AW-1:0]  lat_addr_q, lat_addr_d;

    logic           rd_valid;
    logic [AW-1:0]  rd_base;

    dlk_alloc_table #(
        .SIZE (SIZE),
        .AW   (AW)
    ) u_table (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .clear_i       (clear_i),
        .alloc_valid_i (alloc_valid_i),
        .alloc_addr_i  (alloc_addr_i),
        .free_valid_i  (free_valid_i),
        .free_addr_i   (free_addr_i),
        .rd_idx_i      (idx_q),
        .rd_valid_o    (rd_valid),
        .rd_base_o     (rd_base),
        .full_o        (full_o),
        .count_o       (count_o),
        .alloc_drop_o  (alloc_drop_o)
    );

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        bound_d    = bound_q;
        lat_base_d = lat_base_q;
        lat_addr_d = lat_addr_q;

        if (clear_i) begin
            // Abort silently: no response is produced for an in-flight check.
            state_d = StIdle;
            idx_d   = '0;
            bound_d = AW'(DLK_NO_BOUND);
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (chk_valid_i) begin
                        lat_base_d = chk_base_i;
                        lat_addr_d = chk_addr_i;
                        bound_d    = AW'(DLK_NO_BOUND);
                        idx_d      = '0;
                        state_d    = StScan;
                    end
                end
                StScan: begin
                    // Live table read: allocs/frees during the scan are seen
                    // only if they land before their slot is visited.
                    if (dlk_tightens(rd_valid, DLK_AW'(rd_base), DLK_AW'(lat_base_q),
                                     DLK_AW'(bound_q))) begin
                        bound_d = rd_base;
                    end
                    if (idx_q == IW'(SIZE - 1)) begin
                        state_d = StResp;
                    end else begin
                        idx_d = idx_q + IW'(1);
                    end
                end
                StResp: begin
                    if (rsp_ready_i) begin
                        state_d = StIdle;
                    end
                end
                default: begin
                    state_d = StIdle;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= StIdle;
            idx_q      <= '0;
            bound_q    <= AW'(DLK_NO_BOUND);
            lat_base_q <= '0;
            lat_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            bound_q    <= bound_d;
            lat_base_q <= lat_base_d;
            lat_addr_q <= lat_addr_d;
        end
    end

    assign chk_ready_o    = (state_q == StIdle);
    assign rsp_valid_o    = (state_q == StResp);
    assign rsp_bound_o    = bound_q;
    // With no higher base the bound is all-ones, so only an all-ones address trips it.
    assign rsp_overflow_o = (state_q == StResp) && (lat_addr_q >= bound_q);

endmodule

// File: tb/tb_dlk_write_guard.sv
// tb_dlk_write_guard: scoreboard bench for dlk_write_guard with SIZE=4.
// Requests push their expected {overflow, bound, request cycle} into a queue;
// a monitor on the falling edge compares every presented response against the
// queue head and pops it on the handshake. Table state is checked directly.

module tb_dlk_write_guard;

    localparam int unsigned SIZE = 4;
    localparam int unsigned AW   = 32;
    localparam int unsigned IW   = $clog2(SIZE);

    logic          clk;
    logic          rst_n;
    logic          clear;
    logic          alloc_valid;
    logic [AW-1:0] alloc_addr;
    logic          free_valid;
    logic [AW-1:0] free_addr;
    logic          chk_valid;
    logic          chk_ready;
    logic [AW-1:0] chk_base;
    logic [AW-1:0] chk_addr;
    logic          rsp_valid;
    logic          rsp_ready;
    logic          rsp_overflow;
    logic [AW-1:0] rsp_bound;
    logic          full;
    logic [IW:0]   count;
    logic          alloc_drop;

    dlk_write_guard #(
        .SIZE (SIZE),
        .AW   (AW)
    ) u_dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .clear_i        (clear),
        .alloc_valid_i  (alloc_valid),
        .alloc_addr_i   (alloc_addr),
        .free_valid_i   (free_valid),
        .free_addr_i    (free_addr),
        .chk_valid_i    (chk_valid),
        .chk_ready_o    (chk_ready),
        .chk_base_i     (chk_base),
        .chk_addr_i     (chk_addr),
        .rsp_valid_o    (rsp_valid),
        .rsp_ready_i    (rsp_ready),
        .rsp_overflow_o (rsp_overflow),
        .rsp_bound_o    (rsp_bound),
        .full_o         (full),
        .count_o        (count),
        .alloc_drop_o   (alloc_drop)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic          ovf;
        logic [AW-1:0] bound;
        int            req;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;
    int   ncyc   = 0;

    task automatic check(input string name, input logic [AW-1:0] act, input logic [AW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: compare each presented response against the queue head.
    initial begin
        int   first;
        bit   seen;
        exp_t e;
        seen  = 1'b0;
        first = 0;
        forever begin
            @(negedge clk);
            ncyc++;
            if (!rst_n) begin
                seen = 1'b0;
            end else if (rsp_valid) begin
                if (!seen) begin
                    seen  = 1'b1;
                    first = ncyc;
                end
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_rsp: got rsp_valid=1 expected 0 (t=%0t)", $time);
                end else begin
                    e = sb[0];
                    check("rsp_overflow", AW'(rsp_overflow), AW'(e.ovf));
                    check("rsp_bound", rsp_bound, e.bound);
                    check("chk_ready_busy", AW'(chk_ready), 0);
                    if (rsp_ready) begin
                        check("rsp_latency", AW'(first - e.req), AW'(SIZE + 1));
                        void'(sb.pop_front());
                        seen = 1'b0;
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    task automatic do_alloc(input logic [AW-1:0] a);
        alloc_valid = 1'b1;
        alloc_addr  = a;
        tick();
        alloc_valid = 1'b0;
    endtask

    task automatic do_free(input logic [AW-1:0] a);
        free_valid = 1'b1;
        free_addr  = a;
        tick();
        free_valid = 1'b0;
    endtask

    task automatic do_both(input logic [AW-1:0] a, input logic [AW-1:0] f);
        alloc_valid = 1'b1;
        alloc_addr  = a;
        free_valid  = 1'b1;
        free_addr   = f;
        tick();
        alloc_valid = 1'b0;
        free_valid  = 1'b0;
    endtask

    // Returns one cycle after acceptance, i.e. during the idx 0 scan cycle.
    task automatic issue(input logic [AW-1:0] base, input logic [AW-1:0] addr,
                         input logic ovf, input logic [AW-1:0] bound, input bit push);
        int n;
        n = 0;
        while (!chk_ready && n < 50) begin
            tick();
            n++;
        end
        if (!chk_ready) begin
            checks++;
            errors++;
            $display("FAIL issue_timeout: got chk_ready=0 expected 1 (t=%0t)", $time);
        end
        chk_valid = 1'b1;
        chk_base  = base;
        chk_addr  = addr;
        if (push) sb.push_back('{ovf: ovf, bound: bound, req: ncyc + 1});
        tick();
        chk_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((sb.size() != 0 || !chk_ready) && n < 100) begin
            tick();
            n++;
        end
        if (sb.size() != 0 || !chk_ready) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: got pending=%0d expected 0 (t=%0t)", sb.size(), $time);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish (t=%0t)", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst_n       = 1'b0;
        clear       = 1'b0;
        alloc_valid = 1'b0;
        alloc_addr  = '0;
        free_valid  = 1'b0;
        free_addr   = '0;
        chk_valid   = 1'b0;
        chk_base    = '0;
        chk_addr    = '0;
        rsp_ready   = 1'b1;
        #12;
        check("rst_chk_ready", AW'(chk_ready), 1);
        check("rst_rsp_valid", AW'(rsp_valid), 0);
        check("rst_rsp_overflow", AW'(rsp_overflow), 0);
        check("rst_rsp_bound", rsp_bound, 32'hFFFF_FFFF);
        check("rst_count", AW'(count), 0);
        check("rst_full", AW'(full), 0);
        check("rst_drop", AW'(alloc_drop), 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Basic bound search.
        do_alloc(32'h100);
        do_alloc(32'h200);
        do_alloc(32'h300);
        check("count_3", AW'(count), 3);
        issue(32'h100, 32'h1F0, 1'b0, 32'h200, 1'b1);
        drain();
        issue(32'h100, 32'h200, 1'b1, 32'h200, 1'b1);
        drain();

        // Duplicates, fill, drop, slot reuse.
        do_clear();
        check("clear_count", AW'(count), 0);
        do_alloc(32'h100);
        do_alloc(32'h100);
        check("dup_count", AW'(count), 1);
        do_alloc(32'h200);
        do_alloc(32'h300);
        do_alloc(32'h400);
        check("fill_count", AW'(count), 4);
        check("fill_full", AW'(full), 1);
        check("fill_drop", AW'(alloc_drop), 0);
        do_alloc(32'h500);
        check("drop_set", AW'(alloc_drop), 1);
        check("drop_count", AW'(count), 4);
        do_free(32'h200);
        check("free_count", AW'(count), 3);
        check("free_full", AW'(full), 0);
        do_alloc(32'h500);
        check("reuse_count", AW'(count), 4);
        check("drop_sticky", AW'(alloc_drop), 1);
        // 0x500 must sit in slot 1: freeing it while slot 2 is scanned cannot hide it.
        issue(32'h400, 32'h4FF, 1'b0, 32'h500, 1'b1);
        tick();
        tick();
        do_free(32'h500);
        drain();

        // No higher base: all-ones bound.
        do_clear();
        check("clear_drop", AW'(alloc_drop), 0);
        check("clear_full", AW'(full), 0);
        do_alloc(32'h300);
        issue(32'h300, 32'hFFFF_FFFE, 1'b0, 32'hFFFF_FFFF, 1'b1);
        drain();
        issue(32'h300, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF, 1'b1);
        drain();

        // Same-cycle alloc/free.
        do_clear();
        do_alloc(32'h100);
        do_alloc(32'h200);
        do_alloc(32'h300);
        do_alloc(32'h400);
        do_both(32'h600, 32'h100);
        check("both_full_count", AW'(count), 3);
        check("both_full_drop", AW'(alloc_drop), 1);
        do_both(32'h700, 32'h700);
        check("both_same_count", AW'(count), 3);
        // Address below base; neither 0x600 nor 0x700 may be present.
        issue(32'h400, 32'h10, 1'b0, 32'hFFFF_FFFF, 1'b1);
        drain();

        // Free during scan after the slot was visited, then before accept.
        do_clear();
        do_alloc(32'h200);
        do_alloc(32'h300);
        do_alloc(32'h100);
        issue(32'h100, 32'h250, 1'b1, 32'h200, 1'b1);
        tick();
        do_free(32'h200);
        drain();
        do_alloc(32'h200);
        do_free(32'h200);
        check("refree_count", AW'(count), 2);
        issue(32'h100, 32'h250, 1'b0, 32'h300, 1'b1);
        drain();

        // Response held under back-pressure.
        rsp_ready = 1'b0;
        issue(32'h100, 32'h350, 1'b1, 32'h300, 1'b1);
        repeat (15) tick();
        check("hold_chk_ready", AW'(chk_ready), 0);
        check("hold_rsp_valid", AW'(rsp_valid), 1);
        rsp_ready = 1'b1;
        drain();

        // Clear mid-scan: no response, table emptied.
        issue(32'h0, 32'h0, 1'b0, 32'h0, 1'b0);
        tick();
        do_clear();
        repeat (SIZE + 4) tick();
        check("abort_count", AW'(count), 0);
        check("abort_chk_ready", AW'(chk_ready), 1);
        check("abort_rsp_valid", AW'(rsp_valid), 0);

        // Asynchronous reset while a response is held.
        do_alloc(32'h100);
        do_alloc(32'h200);
        rsp_ready = 1'b0;
        issue(32'h100, 32'h200, 1'b1, 32'h200, 1'b1);
        n = 0;
        while (!rsp_valid && n < 20) begin
            tick();
            n++;
        end
        check("pre_reset_rsp_valid", AW'(rsp_valid), 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_chk_ready", AW'(chk_ready), 1);
        check("arst_rsp_valid", AW'(rsp_valid), 0);
        check("arst_rsp_overflow", AW'(rsp_overflow), 0);
        check("arst_rsp_bound", rsp_bound, 32'hFFFF_FFFF);
        check("arst_count", AW'(count), 0);
        check("arst_full", AW'(full), 0);
        check("arst_drop", AW'(alloc_drop), 0);
        sb.delete();
        tick();
        tick();
        rst_n     = 1'b1;
        rsp_ready = 1'b1;
        repeat (3) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
